// File: rtl/fifo_wr_arb.sv
// ============================================================================
// Module   : fifo_wr_arb
// Brief    : Round-robin burst arbiter sharing one FIFO write port among
//            NUM_REQ valid/ready producers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       fifo_wr_en_o,
    output logic [WIDTH-1:0]           fifo_data_in_o,
    input  logic                       fifo_full_i,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0] pick;
    logic             any_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             xfer;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Scan from the farthest offset down so the nearest valid to rr_ptr wins.
    always_comb begin
        pick      = '0;
        any_valid = |req_valid_i;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int cand;
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_valid_i[cand]) begin
                pick = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = pick;
        if (state_q == ST_IDLE) begin
            gnt_vld = any_valid;
        end else begin
            gnt_vld = req_valid_i[owner_q];
            gnt_idx = owner_q;
        end
        if (srst_i) begin
            gnt_vld = 1'b0;
        end
    end

    // Full gates the write combinationally so a full FIFO is never written.
    assign xfer = gnt_vld && !fifo_full_i;

    always_comb begin
        req_ready_o          = '0;
        req_ready_o[gnt_idx] = xfer;
    end

    assign fifo_wr_en_o   = xfer;
    assign fifo_data_in_o = gnt_vld ? req_data_i[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
    assign owner_o        = owner_q;
    assign busy_o         = (state_q == ST_OWN) && !srst_i;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid && !fifo_full_i) begin
                    owner_d = pick;
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = wrap_inc(pick);
                    end else begin
                        state_d    = ST_OWN;
                        beat_cnt_d = 4'd1;
                    end
                end
            end
            ST_OWN: begin
                if (req_valid_i[owner_q]) begin
                    if (!fifo_full_i) begin
                        if (beat_cnt_q + 4'd1 == 4'(MAX_BURST)) begin
                            state_d    = ST_IDLE;
                            rr_ptr_d   = wrap_inc(owner_q);
                            beat_cnt_d = 4'd0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 4'd1;
                        end
                    end
                end else begin
                    // Owner dropped valid: give up the rest of the burst.
                    state_d    = ST_IDLE;
                    rr_ptr_d   = wrap_inc(owner_q);
                    beat_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
// ============================================================================
// Module   : tb_fifo_wr_arb
// Brief    : Directed self-checking bench for fifo_wr_arb with a small FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arb;

    localparam int NR    = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          srst;
    logic [NR-1:0] req_valid;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          wr_en;
    logic [W-1:0]  din;
    logic          full;
    logic [1:0]    owner;
    logic          busy;

    logic [7:0]    fifo_q[$];
    int            fifo_cnt = 0;
    logic          fifo_rd  = 1'b0;
    logic          fifo_clr = 1'b0;
    int            fifo_pre = 0;

    logic [7:0]    pdata[NR];
    int            prem[NR];

    int            n_cmp  = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .fifo_wr_en_o   (wr_en),
        .fifo_data_in_o (din),
        .fifo_full_i    (full),
        .owner_o        (owner),
        .busy_o         (busy)
    );

    assign full = (fifo_cnt >= DEPTH);

    // FIFO model; a clear may preload filler entries (0xEE).
    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_q.delete();
            for (int i = 0; i < fifo_pre; i++) fifo_q.push_back(8'hEE);
        end else begin
            if (wr_en) fifo_q.push_back(din);
            if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        fifo_cnt <= fifo_q.size();
    end

    task automatic drive_cycle(output logic [3:0] rdy, output logic wr,
                               output logic [7:0] d, output logic bsy,
                               output logic [1:0] own);
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = (prem[i] > 0);
            req_data[i*W +: W] = pdata[i];
        end
        #1;
        rdy = req_ready;
        wr  = wr_en;
        d   = din;
        bsy = busy;
        own = owner;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (rdy[i]) begin
                pdata[i] = pdata[i] + 8'd1;
                prem[i]  = prem[i] - 1;
            end
        end
    endtask

    task automatic do_reset(input int pre);
        for (int i = 0; i < NR; i++) begin
            prem[i]  = 0;
            pdata[i] = 8'h00;
        end
        req_valid = '0;
        req_data  = '0;
        fifo_pre  = pre;
        fifo_clr  = 1'b1;
        srst      = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        srst     = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] rdy; logic wr; logic [7:0] d; logic bsy; logic [1:0] own;
        srst     = 1'b1;
        fifo_pre = 0;
        fifo_clr = 1'b1;
        for (int i = 0; i < NR; i++) begin
            prem[i]  = 1;
            pdata[i] = 8'(8'h50 + i);
        end
        req_valid = '1;
        req_data  = '0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            drive_cycle(rdy, wr, d, bsy, own);
            n_cmp++; if (wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr c%0d: got %b want 0", c, wr); end
            n_cmp++; if (rdy !== 4'b0) begin n_fail++; $display("FAIL reset_ready c%0d: got %b want 0000", c, rdy); end
            n_cmp++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c%0d: got %b want 0", c, bsy); end
            n_cmp++; if (own !== 2'd0) begin n_fail++; $display("FAIL reset_owner c%0d: got %0d want 0", c, own); end
        end
        srst     = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic test_single_producer();
        logic [3:0] rdy; logic wr; logic [7:0] d; logic bsy; logic [1:0] own;
        logic       exp_wr[8]   = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic [7:0] exp_d[8]    = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h00, 8'h00};
        logic       exp_bsy[8]  = '{0, 1, 1, 1, 0, 1, 1, 0};
        do_reset(0);
        prem[2]  = 6;
        pdata[2] = 8'h20;
        for (int c = 0; c < 8; c++) begin
            drive_cycle(rdy, wr, d, bsy, own);
            n_cmp++; if (wr !== exp_wr[c]) begin n_fail++; $display("FAIL single_wr c%0d: got %b want %b", c, wr, exp_wr[c]); end
            n_cmp++; if (d !== exp_d[c]) begin n_fail++; $display("FAIL single_data c%0d: got %h want %h", c, d, exp_d[c]); end
            n_cmp++; if (bsy !== exp_bsy[c]) begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", c, bsy, exp_bsy[c]); end
        end
        n_cmp++; if (fifo_q.size() != 6) begin n_fail++; $display("FAIL single_fifo_size: got %0d want 6", fifo_q.size()); end
        for (int i = 0; i < 6 && i < fifo_q.size(); i++) begin
            n_cmp++; if (fifo_q[i] !== 8'(8'h20 + i)) begin n_fail++; $display("FAIL single_fifo[%0d]: got %h want %h", i, fifo_q[i], 8'(8'h20 + i)); end
        end
    endtask

    task automatic test_all_four();
        logic [3:0] rdy; logic wr; logic [7:0] d; logic bsy; logic [1:0] own;
        int o; logic [3:0] exp_rdy; logic [7:0] exp_d;
        do_reset(0);
        for (int i = 0; i < NR; i++) begin
            prem[i]  = 8;
            pdata[i] = 8'(i * 16);
        end
        fifo_rd = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive_cycle(rdy, wr, d, bsy, own);
            o       = (c / 4) % 4;
            exp_rdy = 4'(1 << o);
            exp_d   = 8'(o * 16 + ((c >= 16) ? 4 : 0) + (c % 4));
            n_cmp++; if (wr !== 1'b1) begin n_fail++; $display("FAIL rr_wr c%0d: got %b want 1", c, wr); end
            n_cmp++; if (rdy !== exp_rdy) begin n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, rdy, exp_rdy); end
            n_cmp++; if (d !== exp_d) begin n_fail++; $display("FAIL rr_data c%0d: got %h want %h", c, d, exp_d); end
        end
        fifo_rd = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] rdy; logic wr; logic [7:0] d; logic bsy; logic [1:0] own;
        logic       exp_wr[7]  = '{1, 0, 0, 0, 1, 0, 0};
        logic [3:0] exp_rdy[7] = '{4'b0001, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0};
        logic       exp_bsy[7] = '{0, 1, 1, 1, 1, 1, 0};
        do_reset(7);
        prem[0] = 2; pdata[0] = 8'h00;
        prem[1] = 1; pdata[1] = 8'h10;
        for (int c = 0; c < 7; c++) begin
            fifo_rd = (c == 3);
            drive_cycle(rdy, wr, d, bsy, own);
            n_cmp++; if (wr !== exp_wr[c]) begin n_fail++; $display("FAIL bp_wr c%0d: got %b want %b", c, wr, exp_wr[c]); end
            n_cmp++; if (rdy !== exp_rdy[c]) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want %b", c, rdy, exp_rdy[c]); end
            n_cmp++; if (bsy !== exp_bsy[c]) begin n_fail++; $display("FAIL bp_busy c%0d: got %b want %b", c, bsy, exp_bsy[c]); end
            if (c >= 1 && c <= 3) begin
                n_cmp++; if (own !== 2'd0) begin n_fail++; $display("FAIL bp_owner c%0d: got %0d want 0", c, own); end
            end
        end
        fifo_rd = 1'b0;
        n_cmp++; if (fifo_q.size() != 8) begin n_fail++; $display("FAIL bp_fifo_size: got %0d want 8", fifo_q.size()); end
        if (fifo_q.size() == 8) begin
            n_cmp++; if (fifo_q[5] !== 8'hEE) begin n_fail++; $display("FAIL bp_fifo[5]: got %h want ee", fifo_q[5]); end
            n_cmp++; if (fifo_q[6] !== 8'h00) begin n_fail++; $display("FAIL bp_fifo[6]: got %h want 00", fifo_q[6]); end
            n_cmp++; if (fifo_q[7] !== 8'h01) begin n_fail++; $display("FAIL bp_fifo[7]: got %h want 01", fifo_q[7]); end
        end
    endtask

    task automatic test_early_release();
        logic [3:0] rdy; logic wr; logic [7:0] d; logic bsy; logic [1:0] own;
        logic [3:0] exp_rdy[8] = '{4'b0010, 4'b0010, 4'b0, 4'b1000, 4'b1000, 4'b1000, 4'b0, 4'b0001};
        logic [7:0] exp_d[8]   = '{8'h10, 8'h11, 8'h00, 8'h30, 8'h31, 8'h32, 8'h00, 8'h00};
        logic [7:0] exp_f[6]   = '{8'h10, 8'h11, 8'h30, 8'h31, 8'h32, 8'h00};
        do_reset(0);
        prem[1] = 2; pdata[1] = 8'h10;
        prem[3] = 3; pdata[3] = 8'h30;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                prem[0] = 1; pdata[0] = 8'h00;
            end
            drive_cycle(rdy, wr, d, bsy, own);
            n_cmp++; if (rdy !== exp_rdy[c]) begin n_fail++; $display("FAIL rel_ready c%0d: got %b want %b", c, rdy, exp_rdy[c]); end
            n_cmp++; if (wr !== (exp_rdy[c] != 4'b0)) begin n_fail++; $display("FAIL rel_wr c%0d: got %b want %b", c, wr, exp_rdy[c] != 4'b0); end
            n_cmp++; if (d !== exp_d[c]) begin n_fail++; $display("FAIL rel_data c%0d: got %h want %h", c, d, exp_d[c]); end
        end
        n_cmp++; if (fifo_q.size() != 6) begin n_fail++; $display("FAIL rel_fifo_size: got %0d want 6", fifo_q.size()); end
        for (int i = 0; i < 6 && i < fifo_q.size(); i++) begin
            n_cmp++; if (fifo_q[i] !== exp_f[i]) begin n_fail++; $display("FAIL rel_fifo[%0d]: got %h want %h", i, fifo_q[i], exp_f[i]); end
        end
    endtask

    task automatic test_mid_burst_reset();
        logic [3:0] rdy; logic wr; logic [7:0] d; logic bsy; logic [1:0] own;
        logic [3:0] exp_rdy[5] = '{4'b0100, 4'b0, 4'b1000, 4'b0, 4'b0010};
        logic [7:0] exp_d[5]   = '{8'h20, 8'h00, 8'h30, 8'h00, 8'h10};
        logic       exp_bsy[5] = '{0, 1, 0, 0, 0};
        logic [7:0] exp_f[3]   = '{8'h20, 8'h30, 8'h10};
        do_reset(0);
        prem[2] = 1; pdata[2] = 8'h20;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                prem[3] = 4; pdata[3] = 8'h30;
                prem[1] = 2; pdata[1] = 8'h10;
            end
            srst = (c == 3);
            drive_cycle(rdy, wr, d, bsy, own);
            n_cmp++; if (rdy !== exp_rdy[c]) begin n_fail++; $display("FAIL mrst_ready c%0d: got %b want %b", c, rdy, exp_rdy[c]); end
            n_cmp++; if (wr !== (exp_rdy[c] != 4'b0)) begin n_fail++; $display("FAIL mrst_wr c%0d: got %b want %b", c, wr, exp_rdy[c] != 4'b0); end
            n_cmp++; if (d !== exp_d[c]) begin n_fail++; $display("FAIL mrst_data c%0d: got %h want %h", c, d, exp_d[c]); end
            n_cmp++; if (bsy !== exp_bsy[c]) begin n_fail++; $display("FAIL mrst_busy c%0d: got %b want %b", c, bsy, exp_bsy[c]); end
        end
        srst = 1'b0;
        n_cmp++; if (fifo_q.size() != 3) begin n_fail++; $display("FAIL mrst_fifo_size: got %0d want 3", fifo_q.size()); end
        for (int i = 0; i < 3 && i < fifo_q.size(); i++) begin
            n_cmp++; if (fifo_q[i] !== exp_f[i]) begin n_fail++; $display("FAIL mrst_fifo[%0d]: got %h want %h", i, fifo_q[i], exp_f[i]); end
        end
    endtask

    initial begin
        srst      = 1'b1;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            prem[i]  = 0;
            pdata[i] = 8'h00;
        end
        test_reset();
        test_single_producer();
        test_all_four();
        test_backpressure();
        test_early_release();
        test_mid_burst_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
